// File: rtl/matbi_watch_pkg.sv
// Shared state encoding, field widths and limits for the matbi watch controller.
package matbi_watch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    SET   = 2'd3
  } state_t;

  localparam int SEC_W      = 6;
  localparam int MIN_W      = 6;
  localparam int HOUR_W     = 5;
  localparam int TIME_LIMIT = 60;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIME_LIMIT - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(TIME_LIMIT - 1);

endpackage

// File: rtl/matbi_tick_div.sv
// Seconds prescaler: counts enabled cycles and flags the terminal count.
// tick is combinational; the owner registers it alongside the time update.
module matbi_tick_div #(
  parameter int P_COUNT_BIT = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  output logic                   tick
);

  logic [P_COUNT_BIT-1:0] cnt;
  logic [P_COUNT_BIT-1:0] last;

  // A zero frequency behaves like one: terminal count is 0, tick every cycle.
  always_comb begin
    last = '0;
    if (i_freq != '0) last = i_freq - P_COUNT_BIT'(1);
  end

  assign tick = enable && !clear && (cnt == last);

  // A count already past 'last' (after a frequency drop) wraps through 2^N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + P_COUNT_BIT'(1);
  end

endmodule

// File: rtl/matbi_watch_ctrl.sv
// Watch controller: IDLE/RUN/PAUSE/SET FSM, prescaled seconds and hh:mm:ss counters.
// Optional alarm comparator enabled by defining MATBI_WATCH_ALARM_EN.
module matbi_watch_ctrl
  import matbi_watch_pkg::*;
#(
  parameter int P_COUNT_BIT = 30,
  parameter int P_HOUR_MAX  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_clear,
  input  logic                   i_set_en,
  input  logic                   i_set_sec,
  input  logic                   i_set_min,
  input  logic                   i_set_hour,
  input  logic [MIN_W-1:0]       i_alarm_min,
  input  logic [HOUR_W-1:0]      i_alarm_hour,
  output logic [1:0]             o_state,
  output logic                   o_run,
  output logic                   o_sec_tick,
  output logic [SEC_W-1:0]       o_sec,
  output logic [MIN_W-1:0]       o_min,
  output logic [HOUR_W-1:0]      o_hour,
  output logic                   o_alarm
);

  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(P_HOUR_MAX - 1);

  state_t state, state_nx;
  logic   tick;
  logic   div_clear;

  logic              sec_wrap, min_wrap, hour_wrap;
  logic [SEC_W-1:0]  sec_inc, tick_sec;
  logic [MIN_W-1:0]  min_inc, tick_min;
  logic [HOUR_W-1:0] hour_inc, tick_hour;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Priority: clear > set_en > stop > start; set_en has no effect in RUN.
  always_comb begin
    state_nx = state;
    if (i_clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (i_set_en)      state_nx = SET;
          else if (i_stop)   state_nx = state;
          else if (i_start)  state_nx = RUN;
        end
        RUN:     if (i_stop) state_nx = PAUSE;
        SET:     if (!i_set_en) state_nx = PAUSE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign o_state   = state;
  assign o_run     = (state == RUN);
  assign div_clear = (state_nx == IDLE) || (state_nx == SET);

  matbi_tick_div #(.P_COUNT_BIT(P_COUNT_BIT)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .enable (state == RUN),
    .clear  (div_clear),
    .i_freq (i_freq),
    .tick   (tick)
  );

  always_comb begin
    sec_wrap  = (o_sec  == SEC_LAST);
    min_wrap  = (o_min  == MIN_LAST);
    hour_wrap = (o_hour == HOUR_LAST);
    sec_inc   = sec_wrap  ? '0 : o_sec  + SEC_W'(1);
    min_inc   = min_wrap  ? '0 : o_min  + MIN_W'(1);
    hour_inc  = hour_wrap ? '0 : o_hour + HOUR_W'(1);
    tick_sec  = sec_inc;
    tick_min  = sec_wrap ? min_inc : o_min;
    tick_hour = (sec_wrap && min_wrap) ? hour_inc : o_hour;
  end

  // SET pulses wrap each field independently, without carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_sec      <= '0;
      o_min      <= '0;
      o_hour     <= '0;
      o_sec_tick <= 1'b0;
    end else begin
      o_sec_tick <= tick;
      if (i_clear) begin
        o_sec  <= '0;
        o_min  <= '0;
        o_hour <= '0;
      end else if (tick) begin
        o_sec  <= tick_sec;
        o_min  <= tick_min;
        o_hour <= tick_hour;
      end else if (state == SET) begin
        if (i_set_sec)  o_sec  <= sec_inc;
        if (i_set_min)  o_min  <= min_inc;
        if (i_set_hour) o_hour <= hour_inc;
      end
    end
  end

`ifdef MATBI_WATCH_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= tick && (tick_sec == '0) &&
                          (tick_min == i_alarm_min) && (tick_hour == i_alarm_hour);
  end

  assign o_alarm = alarm_q;
`else
  logic unused_alarm_in;
  assign unused_alarm_in = ^{i_alarm_min, i_alarm_hour};
  assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_matbi_watch_ctrl.sv
// Directed bench for matbi_watch_ctrl: FSM/SET vector table plus timing sequences.
module tb_matbi_watch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] i_freq;
  logic        i_start, i_stop, i_clear, i_set_en;
  logic        i_set_sec, i_set_min, i_set_hour;
  logic [5:0]  i_alarm_min;
  logic [4:0]  i_alarm_hour;
  logic [1:0]  o_state;
  logic        o_run, o_sec_tick, o_alarm;
  logic [5:0]  o_sec, o_min;
  logic [4:0]  o_hour;

  int errors = 0;
  int checks = 0;

  matbi_watch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_freq       (i_freq),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_clear      (i_clear),
    .i_set_en     (i_set_en),
    .i_set_sec    (i_set_sec),
    .i_set_min    (i_set_min),
    .i_set_hour   (i_set_hour),
    .i_alarm_min  (i_alarm_min),
    .i_alarm_hour (i_alarm_hour),
    .o_state      (o_state),
    .o_run        (o_run),
    .o_sec_tick   (o_sec_tick),
    .o_sec        (o_sec),
    .o_min        (o_min),
    .o_hour       (o_hour),
    .o_alarm      (o_alarm)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] in;      // {start, stop, clear, set_en, set_sec, set_min, set_hour}
    logic [1:0] e_state;
    logic [5:0] e_sec;
    logic [5:0] e_min;
    logic [4:0] e_hour;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [6:0] in, input logic [1:0] st,
                              input int h, input int m, input int s);
    vec_t v;
    v.in      = in;
    v.e_state = st;
    v.e_hour  = 5'(h);
    v.e_min   = 6'(m);
    v.e_sec   = 6'(s);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (o_sec_tick) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, "_hour"}, int'(o_hour), h);
    check({name, "_min"},  int'(o_min),  m);
    check({name, "_sec"},  int'(o_sec),  s);
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Leaves the DUT in SET holding h:m:s.
  task automatic preload(input int h, input int m, input int s);
    pulse_clear();
    i_set_en = 1'b1;
    step();
    for (int i = 0; i < 60; i++) begin
      i_set_sec  = (i < s);
      i_set_min  = (i < m);
      i_set_hour = (i < h);
      step();
    end
    i_set_sec  = 1'b0;
    i_set_min  = 1'b0;
    i_set_hour = 1'b0;
  endtask

  int n, nt, na, a_sec, a_min, a_tick;

  initial begin
    reset = 1'b1;
    i_freq = 30'd1000;
    {i_start, i_stop, i_clear, i_set_en, i_set_sec, i_set_min, i_set_hour} = '0;
    i_alarm_min = '0;
    i_alarm_hour = '0;

    vecs[0]  = mk(7'b0000000, 2'd0, 0, 0, 0);
    vecs[1]  = mk(7'b0001000, 2'd3, 0, 0, 0);
    vecs[2]  = mk(7'b0001100, 2'd3, 0, 0, 1);
    vecs[3]  = mk(7'b0001111, 2'd3, 1, 1, 2);
    vecs[4]  = mk(7'b0000000, 2'd2, 1, 1, 2);
    vecs[5]  = mk(7'b0000100, 2'd2, 1, 1, 2);
    vecs[6]  = mk(7'b1100000, 2'd2, 1, 1, 2);
    vecs[7]  = mk(7'b1000000, 2'd1, 1, 1, 2);
    vecs[8]  = mk(7'b0001000, 2'd1, 1, 1, 2);
    vecs[9]  = mk(7'b0000111, 2'd1, 1, 1, 2);
    vecs[10] = mk(7'b0100000, 2'd2, 1, 1, 2);
    vecs[11] = mk(7'b0011000, 2'd0, 0, 0, 0);
    vecs[12] = mk(7'b1001000, 2'd3, 0, 0, 0);
    vecs[13] = mk(7'b0000000, 2'd2, 0, 0, 0);
    vecs[14] = mk(7'b1000000, 2'd1, 0, 0, 0);
    vecs[15] = mk(7'b0010000, 2'd0, 0, 0, 0);

    // reset state
    step();
    check("rst_state", int'(o_state), 0);
    check("rst_run", int'(o_run), 0);
    check("rst_tick", int'(o_sec_tick), 0);
    check("rst_alarm", int'(o_alarm), 0);
    check_time("rst", 0, 0, 0);
    reset = 1'b0;
    step();

    // FSM / SET vector table (frequency large enough that no tick occurs)
    for (int i = 0; i < 16; i++) begin
      {i_start, i_stop, i_clear, i_set_en, i_set_sec, i_set_min, i_set_hour} = vecs[i].in;
      step();
      check($sformatf("vec%0d_state", i), int'(o_state), int'(vecs[i].e_state));
      check($sformatf("vec%0d_run", i), int'(o_run), int'(vecs[i].e_state == 2'd1));
      check($sformatf("vec%0d_tick", i), int'(o_sec_tick), 0);
      check_time($sformatf("vec%0d", i), int'(vecs[i].e_hour), int'(vecs[i].e_min),
                 int'(vecs[i].e_sec));
    end
    {i_start, i_stop, i_clear, i_set_en, i_set_sec, i_set_min, i_set_hour} = '0;

    // freq 10: first tick 10 cycles after o_run rises, then every 10
    pulse_clear();
    i_freq = 30'd10;
    pulse_start();
    check("f10_run", int'(o_run), 1);
    wait_tick(40, n);
    check("f10_first_gap", n, 10);
    check("f10_sec1", int'(o_sec), 1);
    step();
    check("f10_tick_width", int'(o_sec_tick), 0);
    wait_tick(40, n);
    check("f10_gap2", n, 9);
    check("f10_sec2", int'(o_sec), 2);
    wait_tick(40, n);
    check("f10_gap3", n, 10);
    check("f10_sec3", int'(o_sec), 3);

    // stop coinciding with terminal count still ticks
    pulse_clear();
    i_freq = 30'd4;
    pulse_start();
    repeat (3) step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("stop_tc_tick", int'(o_sec_tick), 1);
    check("stop_tc_state", int'(o_state), 2);
    check("stop_tc_sec", int'(o_sec), 1);

    // freq 8: pause with prescaler 5, hold, resume -> tick after 3 cycles
    pulse_clear();
    i_freq = 30'd8;
    pulse_start();
    repeat (4) step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    nt = 0;
    repeat (20) begin
      step();
      if (o_sec_tick) nt++;
    end
    check("pause_no_tick", nt, 0);
    check("pause_state", int'(o_state), 2);
    pulse_start();
    check("resume_run", int'(o_run), 1);
    wait_tick(20, n);
    check("resume_gap", n, 3);
    check("resume_sec", int'(o_sec), 1);

    // 23:59:58 rolls over to 00:00:00
    preload(23, 59, 58);
    check_time("pre", 23, 59, 58);
    i_set_en = 1'b0;
    step();
    check("pre_pause", int'(o_state), 2);
    i_freq = 30'd4;
    pulse_start();
    wait_tick(20, n);
    check("roll_gap1", n, 4);
    check_time("roll1", 23, 59, 59);
    wait_tick(20, n);
    check("roll_gap2", n, 4);
    check_time("roll2", 0, 0, 0);

    // clear and start together in RUN
    preload(1, 2, 3);
    i_set_en = 1'b0;
    step();
    i_freq = 30'd1000;
    pulse_start();
    i_clear = 1'b1;
    i_start = 1'b1;
    step();
    i_clear = 1'b0;
    i_start = 1'b0;
    check("clr_state", int'(o_state), 0);
    check("clr_run", int'(o_run), 0);
    check_time("clr", 0, 0, 0);

    // SET seconds wrap without carry
    preload(0, 5, 59);
    check("setw_pre_sec", int'(o_sec), 59);
    i_set_sec = 1'b1;
    step();
    i_set_sec = 1'b0;
    check_time("setw", 0, 5, 0);
    i_set_en = 1'b0;
    step();

    // reset mid-RUN aborts counting
    pulse_clear();
    i_freq = 30'd4;
    pulse_start();
    repeat (6) step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", int'(o_state), 0);
    check("arst_run", int'(o_run), 0);
    check("arst_sec", int'(o_sec), 0);
    check("arst_tick", int'(o_sec_tick), 0);
    step();
    reset = 1'b0;
    nt = 0;
    repeat (10) begin
      step();
      if (o_sec_tick) nt++;
    end
    check("arst_no_tick", nt, 0);
    check("arst_idle", int'(o_state), 0);

    // alarm at 00:01 from 00:00:58, freq 2
    i_alarm_min = 6'd1;
    i_alarm_hour = 5'd0;
    preload(0, 0, 58);
    i_set_en = 1'b0;
    step();
    i_freq = 30'd2;
    pulse_start();
    nt = 0; na = 0; a_sec = -1; a_min = -1; a_tick = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_alarm) begin
        na++;
        a_sec = int'(o_sec);
        a_min = int'(o_min);
        a_tick = int'(o_sec_tick);
      end
      if (o_sec_tick) nt++;
      if (nt == 3) break;
    end
    check("alarm_ticks", nt, 3);
`ifdef MATBI_WATCH_ALARM_EN
    check("alarm_count", na, 1);
    check("alarm_sec", a_sec, 0);
    check("alarm_min", a_min, 1);
    check("alarm_with_tick", a_tick, 1);
`else
    check("alarm_count", na, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matbi_watch_ctrl.md
MATBI_WATCH_CTRL -- requirements
Module: matbi_watch_ctrl

Interface
REQ-001 SHALL have parameter P_COUNT_BIT, default 30: width of the prescaler and of i_freq.
REQ-002 SHALL have parameter P_HOUR_MAX, default 24: hour modulus.
REQ-003 SHALL have ports:
- clk  in  1: single clock; all logic on posedge.
- reset  in  1: asynchronous, active-high.
- i_freq  in  P_COUNT_BIT: clk cycles per second.
- i_start  in  1: level; request RUN.
- i_stop  in  1: level; request PAUSE.
- i_clear  in  1: level; return to IDLE and zero the time.
- i_set_en  in  1: level; hold to stay in SET.
- i_set_sec  in  1: one-cycle pulse; increment seconds while in SET.
- i_set_min  in  1: one-cycle pulse; increment minutes while in SET.
- i_set_hour  in  1: one-cycle pulse; increment hours while in SET.
- i_alarm_min  in  6: alarm minute.
- i_alarm_hour  in  5: alarm hour.
- o_state  out  2: current state (IDLE=0, RUN=1, PAUSE=2, SET=3).
- o_run  out  1: high while in RUN.
- o_sec_tick  out  1: one-cycle pulse on each second increment.
- o_sec  out  6: seconds, 0..59.
- o_min  out  6: minutes, 0..59.
- o_hour  out  5: hours, 0..P_HOUR_MAX-1.
- o_alarm  out  1: one-cycle alarm pulse.

Function
REQ-004 SHALL implement a 4-state FSM with the following transitions, all taking effect on the next clock edge:
- IDLE --i_start--> RUN.
- RUN --i_stop--> PAUSE.
- PAUSE --i_start--> RUN.
- IDLE or PAUSE --i_set_en--> SET.
- SET --!i_set_en--> PAUSE.
- any state --i_clear--> IDLE.
REQ-005 SHALL resolve simultaneous requests with priority i_clear > i_set_en > i_stop > i_start; i_set_en SHALL be ignored in RUN.
REQ-006 SHALL increment the prescaler only in RUN; it SHALL hold its value in PAUSE and be zeroed on entering IDLE or SET.
REQ-007 SHALL, on the edge where the prescaler == i_freq-1 in RUN, in one edge: zero the prescaler, assert o_sec_tick for one cycle, and increment the time; i_freq==0 SHALL be treated as 1 (tick every cycle).
REQ-008 SHALL produce the first o_sec_tick i_freq cycles after o_run rises, provided the prescaler starts at 0.
REQ-009 SHALL carry on each tick: sec 59->0 carries into min; min 59->0 carries into hour; hour P_HOUR_MAX-1 -> 0 with no further carry.
REQ-010 SHALL, if the terminal count coincides with i_stop, still perform the tick and the increment; the FSM SHALL enter PAUSE on the same edge.
REQ-011 SHALL, in SET, apply each i_set_* pulse as +1 with wrap and no carry into the next field; simultaneous pulses SHALL each apply to their own field.
REQ-012 SHALL ignore i_set_* pulses outside SET.
REQ-013 SHALL accept an i_freq change mid-count; the comparison uses the current value, and if the prescaler is already beyond i_freq-1 it SHALL wrap through 2^P_COUNT_BIT.
REQ-014 SHALL register o_run from the state (o_run == (o_state==RUN)) with no extra latency.

Reset
REQ-015 SHALL, on reset assertion and asynchronously, set: state IDLE, prescaler 0, o_sec/o_min/o_hour 0, o_sec_tick 0, o_alarm 0, o_run 0.
REQ-016 SHALL treat reset asserted mid-RUN as abort: no tick is emitted, and counting restarts only after a new i_start.

Configuration
REQ-017 SHALL, with macro MATBI_WATCH_ALARM_EN defined, pulse o_alarm for one cycle on a tick whose result time is i_alarm_hour:i_alarm_min:00; this pulse is coincident with o_sec_tick.
REQ-018 SHALL, without MATBI_WATCH_ALARM_EN, keep all ports, tie o_alarm to constant 0, and omit the comparator logic.

Structure
REQ-019 SHALL place the state encoding constants (IDLE/RUN/PAUSE/SET), the seconds/minutes limit 60, and the field widths 6/6/5 in the shared package matbi_watch_pkg.
REQ-020 SHALL place the prescaler in one sub-module, matbi_tick_div (inputs clk, reset, enable, clear, i_freq; output tick); the FSM and time counters stay in the top module.

Verification
REQ-021 SHALL cover: i_freq=10, i_start pulse -> o_sec_tick exactly every 10 cycles, first tick 10 cycles after o_run rises; o_sec counts 1,2,3.
REQ-022 SHALL cover: preload 23:59:58 via SET, i_freq=4, run -> after 2 ticks time reads 00:00:00 and o_hour wraps with no overflow.
REQ-023 SHALL cover: i_freq=8, i_stop at prescaler 5, hold 20 cycles, i_start -> next tick 3 cycles after resume.
REQ-024 SHALL cover: i_clear and i_start in the same cycle during RUN -> IDLE, time 00:00:00, o_run=0.
REQ-025 SHALL cover: in SET at sec=59, pulse i_set_sec -> sec=0 and min unchanged; pulse i_set_sec while in RUN -> no change.
REQ-026 SHALL cover: with MATBI_WATCH_ALARM_EN, alarm 00:01, run from 00:00:58 with i_freq=2 -> single o_alarm pulse at 00:01:00; without the macro, o_alarm remains 0.
